// File: rtl/i2s2_capture_sched.sv
// Capture scheduler for the I2S2 receive PHY: one L/R pair per LRCK frame, mixed/selected, attenuated, sent over valid/ready.
// Optional: define I2S2_SCHED_OVF_CNT_EN to build the saturating dropped-frame counter.
module i2s2_capture_sched #(
  parameter int SAMPLE_W    = 24,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [2:0]          gain_shift,
  input  logic                lrck,
  input  logic [SAMPLE_W-1:0] l_channel,
  input  logic [SAMPLE_W-1:0] r_channel,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                frame_err,
  output logic [15:0]         overflow_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_PROC, S_EMIT_A, S_EMIT_B
  } state_t;

  state_t              state_q, state_d;
  logic                lrck_d;
  logic                frame_ev;
  logic                handshake;
  logic                stop_q;
  logic                timed_out;
  logic [TW-1:0]       to_cnt;
  logic [SAMPLE_W-1:0] l_q, r_q, right_word;
  logic [1:0]          mode_q;
  logic [2:0]          gain_q;
  logic [SAMPLE_W:0]   mono_sum;
  logic [SAMPLE_W-1:0] sel_word, first_word, right_shifted;

  assign frame_ev  = lrck & ~lrck_d;
  assign handshake = out_valid & out_ready;
  assign timed_out = (to_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lrck_d  <= 1'b0;
      busy    <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lrck_d  <= lrck;
      busy    <= (state_q != S_IDLE);
      // A stop request is remembered until the in-flight word has been handed off
      stop_q  <= (state_d != S_IDLE) && (stop_q || !enable);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_ARM;
      S_ARM:    if (!enable) state_d = S_IDLE;
                else if (frame_ev) state_d = S_WAIT;
      S_WAIT:   if (!enable) state_d = S_IDLE;
                else if (frame_ev) state_d = S_PROC;
      S_PROC:   state_d = S_EMIT_A;
      S_EMIT_A: if (handshake) begin
                  if (stop_q || !enable) state_d = S_IDLE;
                  else if (mode_q == 2'd3) state_d = S_EMIT_B;
                  else state_d = S_WAIT;
                end
      S_EMIT_B: if (handshake) state_d = (stop_q || !enable) ? S_IDLE : S_WAIT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Mono average is formed one bit wider so the sum never wraps
  always_comb begin
    mono_sum = {l_q[SAMPLE_W-1], l_q} + {r_q[SAMPLE_W-1], r_q};
    sel_word = l_q;
    case (mode_q)
      2'd0:    sel_word = mono_sum[SAMPLE_W:1];
      2'd2:    sel_word = r_q;
      default: sel_word = l_q;
    endcase
    first_word    = $signed(sel_word) >>> gain_q;
    right_shifted = $signed(r_q) >>> gain_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_q    <= '0;
      r_q    <= '0;
      mode_q <= 2'd0;
      gain_q <= 3'd0;
    end else if (state_q == S_WAIT && enable && frame_ev) begin
      l_q    <= l_channel;
      r_q    <= r_channel;
      mode_q <= mode;
      gain_q <= gain_shift;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data   <= '0;
      out_tag    <= 1'b0;
      out_valid  <= 1'b0;
      right_word <= '0;
    end else begin
      case (state_q)
        S_PROC: begin
          out_data   <= first_word;
          out_tag    <= 1'b0;
          out_valid  <= 1'b1;
          right_word <= right_shifted;
        end
        S_EMIT_A: if (handshake) begin
          if (state_d == S_EMIT_B) begin
            out_data <= right_word;
            out_tag  <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end
        S_EMIT_B: if (handshake) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Watchdog only runs while we are waiting on the PHY for a frame boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else if (state_q == S_ARM || state_q == S_WAIT) begin
      if (frame_ev) to_cnt <= '0;
      else if (!timed_out) to_cnt <= to_cnt + 1'b1;
      if (timed_out) frame_err <= 1'b1;
    end else begin
      to_cnt <= '0;
      if (state_q == S_IDLE) frame_err <= 1'b0;
    end
  end

`ifdef I2S2_SCHED_OVF_CNT_EN
  logic [15:0] ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= '0;
    end else if (frame_ev && ovf_q != 16'hFFFF &&
                 (state_q == S_PROC || state_q == S_EMIT_A || state_q == S_EMIT_B)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign overflow_cnt = ovf_q;
`else
  assign overflow_cnt = 16'd0;
`endif

endmodule

// File: doc/i2s2_capture_sched.md
# i2s2_capture_sched

Capture scheduler and sequencer for the I2S2 PMOD receive PHY. It aligns to the PHY's LRCK frame boundaries and latches one left/right sample pair per frame. It mixes or selects channels, applies a volume attenuation, and delivers samples to a downstream consumer over a valid/ready handshake. It sits between the PHY and the FrontPanel pipe/FIFO logic and replaces ad-hoc per-cycle sampling of the channel buses.

## Interface
- `SAMPLE_W`, 24: width of PHY channel words and output samples (two's complement).
- `TIMEOUT_CYC`, 4096: max `clk` cycles between LRCK rising edges before `frame_err` sets.
- `clk` in 1: system clock, same domain as the PHY.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `enable` in 1: run request from FrontPanel.
- `mode` in 2: 0 mono average, 1 left only, 2 right only, 3 stereo interleaved.
- `gain_shift` in 3: arithmetic right shift applied to each output word (0 = unity).
- `lrck` in 1: PHY LRCK, synchronous to `clk`.
- `l_channel` in SAMPLE_W: PHY left word.
- `r_channel` in SAMPLE_W: PHY right word.
- `out_data` out SAMPLE_W: output sample.
- `out_tag` out 1: 0 = left/mono word, 1 = right word (stereo only).
- `out_valid` out 1: sample valid.
- `out_ready` in 1: consumer accepts the sample on a cycle where `out_valid && out_ready`.
- `busy` out 1: state is not IDLE.
- `frame_err` out 1: sticky LRCK timeout flag.
- `overflow_cnt` out 16: saturating count of dropped frames.

## Operation
- Frame event: `lrck` sampled 1 while its registered copy `lrck_d` is 0.
- States:
  - IDLE: `enable`=1 → ARM.
  - ARM: first frame event discarded (partial frame) → WAIT.
  - WAIT: frame event → latch `l_channel`, `r_channel`, `mode`, `gain_shift` → PROC.
  - PROC (1 cycle): compute word(s), load output register → EMIT_A.
  - EMIT_A: on handshake, mode 3 → EMIT_B; else → WAIT.
  - EMIT_B: on handshake → WAIT.
- Arithmetic:
  - Mono = (sext(L) + sext(R)) >>> 1 on SAMPLE_W+1 bits, truncated to SAMPLE_W. This cannot overflow.
  - Each word is then arithmetic-shifted right by `gain_shift`, rounding toward −inf.
- Mode 3 order: left (`out_tag`=0), then right (`out_tag`=1). Right is presented the cycle after left is accepted.
- Overflow: a frame event in PROC, EMIT_A or EMIT_B drops that frame. `overflow_cnt` increments by 1 and saturates at 0xFFFF. The words being presented are unaffected.
- `enable` deasserted:
  - IDLE, ARM, WAIT: → IDLE next cycle.
  - PROC, EMIT_A, EMIT_B: the current word completes its handshake, then → IDLE. A pending stereo right word is discarded and never presented.
- Timeout: in ARM/WAIT, a cycle counter resets on every frame event. When it reaches TIMEOUT_CYC, `frame_err` sets and the state stays put. `frame_err` clears only in IDLE.
- Reset values: `out_data`=0, `out_tag`=0, `out_valid`=0, `busy`=0, `frame_err`=0, `overflow_cnt`=0, state IDLE, `lrck_d`=0.

## Timing
- Frame event at cycle E → samples latched at end of E → PROC in E+1 → `out_valid`=1 from cycle E+2.
- Once asserted, `out_valid` holds until handshake. `out_data` and `out_tag` are stable while `out_valid && !out_ready`.
- `out_valid` drops the cycle after the final handshake of a frame. With `out_ready` tied high, stereo gives left at E+2 and right at E+3.
- `busy` is registered and reflects the state one cycle after each transition.
- `mode` and `gain_shift` changes apply from the next latched frame only.

## Configuration
- `I2S2_SCHED_OVF_CNT_EN` defined: the 16-bit saturating overflow counter is implemented.
- Undefined: `overflow_cnt` is tied to 0 and no counter logic is built. Drop behaviour is unchanged.

## Test plan
- Reset mid-stereo-frame (`reset`=0 while EMIT_B) → all outputs return to reset values immediately; after `reset`=1, IDLE.
- Mode 0, L=0x7FFFFF, R=0x7FFFFF, gain 0 → one word 0x7FFFFF at E+2, `out_tag`=0. L=0x800000, R=0x7FFFFF → 0xFFFFFF.
- Mode 3, L=0x123456, R=0xFEDCBA, gain 2, `out_ready`=1 → 0x048D15 (tag 0) at E+2, 0xFFB72E (tag 1) at E+3.
- `out_ready`=0 across 3 frame events → first frame's word held stable, `overflow_cnt`=2 (0 when `I2S2_SCHED_OVF_CNT_EN` undefined).
- `lrck` held static with `enable`=1 → `frame_err`=1 after 4096 cycles in WAIT; `enable`=0 → IDLE, flag cleared.
